// File: rtl/imm_pkg.sv
// Shared opcodes, immediate classes and class-to-field-width mapping for the
// immediate generator (prefix support selected by IMM_PREFIX_EN).
package imm_pkg;

  localparam logic [4:0] OPC_PFX_DEF = 5'b00010;
  localparam logic [4:0] OPC_J       = 5'b00100;
  localparam logic [4:0] OPC_JR      = 5'b00101;
  localparam logic [4:0] OPC_JAL     = 5'b00110;
  localparam logic [4:0] OPC_JALR    = 5'b00111;
  localparam logic [4:0] OPC_ADDI    = 5'b01000;
  localparam logic [4:0] OPC_SUBI    = 5'b01001;
  localparam logic [4:0] OPC_XORI    = 5'b01010;
  localparam logic [4:0] OPC_ANDNI   = 5'b01011;
  localparam logic [4:0] OPC_ST      = 5'b10000;
  localparam logic [4:0] OPC_LD      = 5'b10001;
  localparam logic [4:0] OPC_SLBI    = 5'b10010;
  localparam logic [4:0] OPC_STU     = 5'b10011;
  localparam logic [4:0] OPC_LBI     = 5'b11000;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    SIMM5  = 3'd1,
    ZIMM5  = 3'd2,
    SIMM8  = 3'd3,
    ZIMM8  = 3'd4,
    SIMM11 = 3'd5
  } imm_cls_e;

  typedef enum logic {
    IDLE = 1'b0,
    PFX  = 1'b1
  } pfx_state_e;

  function automatic logic [3:0] cls_width(input imm_cls_e cls);
    case (cls)
      SIMM5, ZIMM5: cls_width = 4'd5;
      SIMM8, ZIMM8: cls_width = 4'd8;
      SIMM11:       cls_width = 4'd11;
      default:      cls_width = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode classifier: immediate class, masked raw field and
// signedness. The prefix opcode always classifies as NONE here.
module imm_decode
  import imm_pkg::*;
#(
  parameter logic [4:0] PFX_OPC = OPC_PFX_DEF
) (
  input  logic [4:0]  opc_i,
  input  logic [10:0] fld_i,
  output imm_cls_e    cls_o,
  output logic [10:0] raw_o,
  output logic        sgn_o
);

  always_comb begin
    cls_o = NONE;
    if (opc_i != PFX_OPC) begin
      casez (opc_i)
        OPC_ADDI, OPC_SUBI, OPC_ST, OPC_LD, OPC_STU: cls_o = SIMM5;
        OPC_XORI, OPC_ANDNI:                         cls_o = ZIMM5;
        5'b011??, OPC_LBI, OPC_JR, OPC_JALR:         cls_o = SIMM8;
        OPC_SLBI:                                    cls_o = ZIMM8;
        OPC_J, OPC_JAL:                              cls_o = SIMM11;
        default:                                     cls_o = NONE;
      endcase
    end
    raw_o = fld_i & ~(11'h7FF << cls_width(cls_o));
    sgn_o = (cls_o == SIMM5) || (cls_o == SIMM8) || (cls_o == SIMM11);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake. Defining
// IMM_PREFIX_EN adds the prefix FSM that supplies 11 upper immediate bits.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int         DATA_W  = 16,
  parameter logic [4:0] PFX_OPC = OPC_PFX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_cls,
  output logic [15:0]       out_instr,
  output logic              out_pfx_err
);

  imm_cls_e          cls;
  logic [10:0]       raw;
  logic              sgn;
  logic              accept;
  logic              is_pfx;
  logic              use_pfx;
  logic [4:0]        n_bits;
  logic [4:0]        msb;
  logic [31:0]       comb;
  logic [DATA_W-1:0] imm_d;

  logic              valid_q;
  logic [DATA_W-1:0] imm_q;
  imm_cls_e          cls_q;
  logic [15:0]       instr_q;

  imm_decode #(.PFX_OPC(PFX_OPC)) u_dec (
    .opc_i (in_instr[15:11]),
    .fld_i (in_instr[10:0]),
    .cls_o (cls),
    .raw_o (raw),
    .sgn_o (sgn)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef IMM_PREFIX_EN
  pfx_state_e  state_q;
  logic [10:0] pfx_q;
  logic        pfx_err_q;

  assign is_pfx      = (in_instr[15:11] == PFX_OPC);
  assign use_pfx     = (state_q == PFX);
  assign out_pfx_err = pfx_err_q;
`else
  assign is_pfx      = 1'b0;
  assign use_pfx     = 1'b0;
  assign out_pfx_err = 1'b0;
`endif

  // Field is placed below any prefix bits, then extended from the top bit
  // of the combined width; bits above DATA_W simply fall off.
  always_comb begin
    comb   = 32'(raw);
    n_bits = 5'(cls_width(cls));
`ifdef IMM_PREFIX_EN
    if (use_pfx) begin
      comb   = comb | (32'(pfx_q) << cls_width(cls));
      n_bits = n_bits + 5'd11;
    end
`endif
    msb   = n_bits - 5'd1;
    imm_d = '0;
    if (cls != NONE) begin
      for (int i = 0; i < DATA_W; i++) begin
        imm_d[i] = (i < int'(n_bits)) ? comb[i] : (sgn & comb[msb]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      imm_q     <= '0;
      cls_q     <= NONE;
      instr_q   <= '0;
`ifdef IMM_PREFIX_EN
      pfx_err_q <= 1'b0;
      state_q   <= IDLE;
      pfx_q     <= '0;
`endif
    end else if (flush) begin
      valid_q <= 1'b0;
`ifdef IMM_PREFIX_EN
      state_q <= IDLE;
`endif
    end else if (accept && !is_pfx) begin
      valid_q   <= 1'b1;
      imm_q     <= imm_d;
      cls_q     <= cls;
      instr_q   <= in_instr;
`ifdef IMM_PREFIX_EN
      pfx_err_q <= use_pfx && (cls == NONE);
      state_q   <= IDLE;
`endif
    end else begin
      if (out_ready) valid_q <= 1'b0;
`ifdef IMM_PREFIX_EN
      if (accept) begin
        pfx_q   <= in_instr[10:0];
        state_q <= PFX;
      end
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_imm   = imm_q;
  assign out_cls   = cls_q;
  assign out_instr = instr_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed cases then random traffic,
// checked against an arithmetic reference model (follows IMM_PREFIX_EN).
module tb_imm_gen_pipe;
  import imm_pkg::*;

  localparam int DATA_W = 16;
`ifdef IMM_PREFIX_EN
  localparam bit PFX_EN = 1'b1;
`else
  localparam bit PFX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_instr = '0;
  logic flush = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DATA_W-1:0] out_imm;
  logic [2:0] out_cls;
  logic [15:0] out_instr;
  logic out_pfx_err;

  imm_gen_pipe #(.DATA_W(DATA_W), .PFX_OPC(5'b00010)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_cls(out_cls),
    .out_instr(out_instr), .out_pfx_err(out_pfx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] imm;
    logic [2:0]        cls;
    logic [15:0]       instr;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   exp_ov = 1'b0;
  bit   mdl_ov = 1'b0;
  bit   m_pfx = 1'b0;
  longint m_pfx_val = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Class table by opcode number; returns class, field width and signedness.
  function automatic void ref_cls(input int op, output int cls, output int w, output bit s);
    cls = int'(NONE); w = 0; s = 1'b0;
    case (op)
      8, 9, 16, 17, 19:             begin cls = int'(SIMM5);  w = 5;  s = 1'b1; end
      10, 11:                       begin cls = int'(ZIMM5);  w = 5;  s = 1'b0; end
      12, 13, 14, 15, 24, 5, 7:     begin cls = int'(SIMM8);  w = 8;  s = 1'b1; end
      18:                           begin cls = int'(ZIMM8);  w = 8;  s = 1'b0; end
      4, 6:                         begin cls = int'(SIMM11); w = 11; s = 1'b1; end
      default:                      ;
    endcase
  endfunction

  // Drive one cycle's inputs, advance the model across the next edge.
  task automatic cycle(input bit v, input logic [15:0] ins, input bit rdy,
                       input bit fl, input bit rst = 1'b1);
    bit acc;
    int cls, w, n;
    bit s;
    longint val;
    exp_t e;
    rst_n = rst; in_valid = v; in_instr = ins; flush = fl;
    out_ready = rst ? rdy : 1'b0;
    acc = v && (!mdl_ov || out_ready);
    if (!rst) begin
      mdl_ov = 1'b0; m_pfx = 1'b0; m_pfx_val = 0;
    end else if (fl) begin
      mdl_ov = 1'b0; m_pfx = 1'b0;
    end else if (acc && PFX_EN && int'(ins[15:11]) == 2) begin
      m_pfx = 1'b1; m_pfx_val = longint'(ins[10:0]);
      if (out_ready) mdl_ov = 1'b0;
    end else if (acc) begin
      ref_cls(int'(ins[15:11]), cls, w, s);
      val = longint'(ins[10:0]) % (longint'(1) << w);
      n = w;
      if (m_pfx) begin
        val = m_pfx_val * (longint'(1) << w) + val;
        n = w + 11;
      end
      if (cls == int'(NONE)) val = 0;
      else if (s && val >= (longint'(1) << (n - 1))) val = val - (longint'(1) << n);
      e.imm = val[DATA_W-1:0];
      e.cls = 3'(cls);
      e.instr = ins;
      e.err = m_pfx && (cls == int'(NONE));
      sb.push_back(e);
      mdl_ov = 1'b1; m_pfx = 1'b0;
    end else if (out_ready) begin
      mdl_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    exp_ov = mdl_ov;
    if (!rst) sb.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("in_ready", 32'(in_ready), 32'(!exp_ov || out_ready));
      if (out_valid && exp_ov) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: output present, expected none queued");
        end else begin
          chk("out_imm", 32'(out_imm), 32'(sb[0].imm));
          chk("out_cls", 32'(out_cls), 32'(sb[0].cls));
          chk("out_instr", 32'(out_instr), 32'(sb[0].instr));
          chk("out_pfx_err", 32'(out_pfx_err), 32'(sb[0].err));
          if (rst_n && (flush || out_ready)) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_out_imm", 32'(out_imm), 32'h0);
    chk("rst_out_cls", 32'(out_cls), 32'(NONE));
    chk("rst_out_instr", 32'(out_instr), 32'h0);
    chk("rst_pfx_err", 32'(out_pfx_err), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    mon_en = 1'b1;

    cycle(1'b1, 16'h401F, 1'b1, 1'b0);
    cycle(1'b1, 16'h2400, 1'b1, 1'b0);
    cycle(1'b1, 16'h90FF, 1'b1, 1'b0);
    cycle(1'b1, 16'h1001, 1'b1, 1'b0);
    cycle(1'b1, 16'h4005, 1'b1, 1'b0);
    cycle(1'b1, 16'h1001, 1'b1, 1'b0);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    cycle(1'b1, 16'h401F, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h4001, 1'b0, 1'b0);
    cycle(1'b1, 16'h4001, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    cycle(1'b1, 16'h17FF, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b1);
    cycle(1'b1, 16'h4005, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    cycle(1'b1, 16'h17FF, 1'b0, 1'b0);
    cycle(1'b1, 16'h4005, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h4005, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      logic [4:0]  op;
      logic [10:0] fld;
      op  = ($urandom_range(0, 9) < 2) ? 5'b00010 : 5'($urandom);
      fld = 11'($urandom);
      cycle($urandom_range(0, 3) != 0, {op, fld}, $urandom_range(0, 9) < 7,
            $urandom_range(0, 24) == 0, $urandom_range(0, 299) != 0);
    end

    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
